pipelined_decode_control: RTL and testbench
===========================================

Name: pipelined_decode_control

Overview:
Registered, handshaked successor to the combinational decode/control unit. It sits between fetch and execute and decodes the full RV32I base set: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC. Results land in one output pipeline register with valid/ready flow control. It detects load-use hazards and inserts a bubble, and it supports a synchronous flush.

Parameters:
XLEN, 32, datapath and immediate width; only 32 is supported, kept for package symmetry.
REG_ADDR_W, 5, register-file index width.
ENABLE_HAZARD, 1, 1 enables load-use bubble insertion; 0 disables it (hazard is forced 0).
STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous; kill the output register contents
in_valid  in  1  fetch presents an instruction
in_ready  out  1  decode accepts this cycle
in_instruction  in  32  raw instruction
in_pc  in  XLEN  PC of in_instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute consumes the bundle
out_pc  out  XLEN  registered PC
out_alu_opcode  out  4  ALU operation, encoding per package
out_op1_sel  out  1  0 = PC, 1 = rs1
out_op2_sel  out  1  0 = rs2, 1 = immediate
out_rf_wr_en  out  1  write-back enable
out_rf_wb_sel  out  2  00 = PC+4, 01 = ALU, 10 = memory
out_mem_wr_en  out  1  store
out_mem_rd_en  out  1  load
out_mem_size  out  2  0 = byte, 1 = half, 2 = word
out_mem_sign_ext  out  1  1 for LB/LH; 0 for LBU/LHU/LW
out_immediate  out  XLEN  sign-extended immediate
out_rs1, out_rs2, out_rd  out  REG_ADDR_W  register indices (0 when unused)
out_is_branch, out_is_jal, out_is_jalr  out  1  control-flow class
out_branch_func3  out  3  branch condition
out_illegal  out  1  unrecognised opcode/func3/func7 combination
stall_count  out  STALL_CNT_W  bubbles inserted, saturating

Behaviour:
- Reset, asynchronous on reset_n low: every output register is 0, including out_valid, out_illegal and stall_count. in_ready is therefore 1 after reset.
- Decode logic is combinational on in_instruction. Outputs are registered, so latency is 1 cycle from the accepting edge.
- Advance condition: adv = out_ready | ~out_valid.
- Hazard condition: hz = ENABLE_HAZARD & out_valid & out_mem_rd_en & (out_rd != 0) & (uses_rs1 & rs1 == out_rd | uses_rs2 & rs2 == out_rd).
  - uses_rs1 is true for all types except LUI, AUIPC, JAL.
  - uses_rs2 is true for OP, STORE, BRANCH only.
- in_ready = adv & ~hz & ~flush.
- Register update priority:
  1. flush: out_valid <= 0.
  2. adv & hz: bubble; out_valid <= 0, stall_count += 1 (saturating at all-ones).
  3. adv & in_valid: load the decoded bundle, out_valid <= 1.
  4. adv & ~in_valid: out_valid <= 0.
  5. Otherwise hold. All outputs stay stable while out_valid & ~out_ready.
- Bubble payload fields may hold stale values, but rf_wr_en, mem_wr_en and mem_rd_en are cleared whenever out_valid goes 0.
- ALU mapping:
  - OP uses func3/func7 and covers ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - OP-IMM behaves the same except SUB does not exist; shifts require imm[11:5] = 0 (SRAI 0x20).
  - LOAD, STORE, JALR, AUIPC use ADD.
  - LUI uses PASS_B.
  - BRANCH uses SUB.
  - JAL uses ADD with op1 = PC.
- Immediate formats: I, S, B (bit 0 = 0), U (imm[31:12], low 12 bits zero), J (bit 0 = 0).
- Illegal: out_illegal = 1, and rf_wr_en, mem_wr_en, mem_rd_en are forced 0. The instruction still flows with out_valid = 1.
- Writes to rd = 0 are decoded normally; the register file ignores them.

Decomposition:
- Package decode_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - ALU opcodes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10;
  - WB_SEL and MEM_SIZE constants.
- One sub-module, decode_comb: pure combinational instruction-to-bundle decoder, including uses_rs1/uses_rs2. The top level owns the register, handshake, hazard logic and counter.

Test Plan:
- addi x1,x0,5 (0x00500093) with out_ready=1 -> next cycle out_valid=1, ALU=ADD, imm=5, rd=1, rs1=0, rf_wr_en=1, wb_sel=01, op2_sel=1.
- lw x2,0(x1) (0x0000A103), then add x3,x2,x1 (0x001101B3) back-to-back -> in_ready=0 for one cycle, one bubble (out_valid=0), add issues the cycle after, stall_count=1.
- Same lw/add pair with ENABLE_HAZARD=0 -> no bubble, stall_count stays 0.
- out_ready=0 for 3 cycles while holding addi -> outputs stable, in_ready=0, no instruction lost; resumes in order.
- flush asserted while out_valid=1 -> out_valid=0 next cycle, stall_count unchanged; reset_n pulsed mid-stream -> all outputs 0 immediately.
- lui x5,0x12345 (0x123452B7) -> imm=0x12345000, ALU=PASS_B; 0xFFFFFFFF -> out_illegal=1, rf_wr_en=0, mem_wr_en=0.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared constants, enums and the decoded-bundle struct for the
//                RV32I pipelined decode/control stage.
//                Contents: opcode constants, ALU operation enum, write-back
//                and memory-size selectors, decoded bundle type, and a
//                func3-to-ALU mapping helper shared by OP and OP-IMM.
//  Revision    : 1.0  initial release
// ============================================================================
package decode_pkg;

   localparam int c_XLEN       = 32;
   localparam int c_REG_ADDR_W = 5;

   // Major opcodes (instruction bits [6:0])
   localparam logic [6:0] c_OPC_OP     = 7'b0110011;
   localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
   localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
   localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
   localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   // Write-back source select
   localparam logic [1:0] c_WB_PC4 = 2'b00;
   localparam logic [1:0] c_WB_ALU = 2'b01;
   localparam logic [1:0] c_WB_MEM = 2'b10;

   // Memory access size
   localparam logic [1:0] c_MEM_BYTE = 2'd0;
   localparam logic [1:0] c_MEM_HALF = 2'd1;
   localparam logic [1:0] c_MEM_WORD = 2'd2;

   typedef struct packed {
      alu_op_e                 alu_opcode;
      logic                    op1_sel;
      logic                    op2_sel;
      logic                    rf_wr_en;
      logic [1:0]              rf_wb_sel;
      logic                    mem_wr_en;
      logic                    mem_rd_en;
      logic [1:0]              mem_size;
      logic                    mem_sign_ext;
      logic [c_XLEN-1:0]       immediate;
      logic [c_REG_ADDR_W-1:0] rs1;
      logic [c_REG_ADDR_W-1:0] rs2;
      logic [c_REG_ADDR_W-1:0] rd;
      logic                    is_branch;
      logic                    is_jal;
      logic                    is_jalr;
      logic [2:0]              branch_func3;
      logic                    illegal;
   } decode_bundle_t;

   // func3 -> ALU op for OP/OP-IMM. 'alt' selects SUB (func3=000) or SRA
   // (func3=101); legality of the func7 field is judged by the caller.
   function automatic alu_op_e alu_from_func3(input logic [2:0] func3,
                                              input logic       alt);
      alu_op_e op;
      case (func3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/decode_comb.sv
`default_nettype none
// ============================================================================
//  Module      : decode_comb
//  Description : Purely combinational RV32I instruction decoder. Produces the
//                full control bundle plus the source-register usage flags
//                needed for load-use hazard detection.
//  Ports       : instruction  in  raw 32-bit instruction
//                bundle       out decoded control/immediate/register bundle
//                uses_rs1     out instruction reads rs1
//                uses_rs2     out instruction reads rs2
//  Revision    : 1.0  initial release
// ============================================================================
module decode_comb
   import decode_pkg::*;
(
   input  logic [c_XLEN-1:0] instruction,
   output decode_bundle_t    bundle,
   output logic              uses_rs1,
   output logic              uses_rs2
);

   logic [6:0]              w_opcode;
   logic [2:0]              w_func3;
   logic [6:0]              w_func7;
   logic [c_REG_ADDR_W-1:0] w_rs1;
   logic [c_REG_ADDR_W-1:0] w_rs2;
   logic [c_REG_ADDR_W-1:0] w_rd;
   logic [c_XLEN-1:0]       w_imm_i;
   logic [c_XLEN-1:0]       w_imm_s;
   logic [c_XLEN-1:0]       w_imm_b;
   logic [c_XLEN-1:0]       w_imm_u;
   logic [c_XLEN-1:0]       w_imm_j;
   logic                    w_illegal;

   assign w_opcode = instruction[6:0];
   assign w_rd     = instruction[11:7];
   assign w_func3  = instruction[14:12];
   assign w_rs1    = instruction[19:15];
   assign w_rs2    = instruction[24:20];
   assign w_func7  = instruction[31:25];

   assign w_imm_i = {{20{instruction[31]}}, instruction[31:20]};
   assign w_imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
   assign w_imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
   assign w_imm_u = {instruction[31:12], 12'b0};
   assign w_imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};

   // Fields not used by a given format stay at zero, so unused register
   // indices read as x0 and can never match a hazard.
   always_comb begin
      bundle    = '0;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      w_illegal = 1'b0;

      case (w_opcode)
         c_OPC_OP: begin
            bundle.alu_opcode = alu_from_func3(w_func3, w_func7[5]);
            bundle.op1_sel    = 1'b1;
            bundle.op2_sel    = 1'b0;
            bundle.rf_wr_en   = 1'b1;
            bundle.rf_wb_sel  = c_WB_ALU;
            bundle.rs1        = w_rs1;
            bundle.rs2        = w_rs2;
            bundle.rd         = w_rd;
            uses_rs1          = 1'b1;
            uses_rs2          = 1'b1;
            // Only func7=0x00, or 0x20 with SUB/SRA, is a base-ISA encoding
            if (!((w_func7 == 7'h00) ||
                  ((w_func7 == 7'h20) && ((w_func3 == 3'b000) || (w_func3 == 3'b101)))))
               w_illegal = 1'b1;
         end
         c_OPC_OP_IMM: begin
            // No SUBI: the alt bit only applies to the right shift
            bundle.alu_opcode = alu_from_func3(w_func3, (w_func3 == 3'b101) & w_func7[5]);
            bundle.op1_sel    = 1'b1;
            bundle.op2_sel    = 1'b1;
            bundle.rf_wr_en   = 1'b1;
            bundle.rf_wb_sel  = c_WB_ALU;
            bundle.immediate  = w_imm_i;
            bundle.rs1        = w_rs1;
            bundle.rd         = w_rd;
            uses_rs1          = 1'b1;
            if ((w_func3 == 3'b001) && (w_func7 != 7'h00))
               w_illegal = 1'b1;
            if ((w_func3 == 3'b101) && (w_func7 != 7'h00) && (w_func7 != 7'h20))
               w_illegal = 1'b1;
         end
         c_OPC_LOAD: begin
            bundle.alu_opcode   = ALU_ADD;
            bundle.op1_sel      = 1'b1;
            bundle.op2_sel      = 1'b1;
            bundle.rf_wr_en     = 1'b1;
            bundle.rf_wb_sel    = c_WB_MEM;
            bundle.mem_rd_en    = 1'b1;
            bundle.mem_size     = w_func3[1:0];
            // Sign-extend only LB/LH; LW and the unsigned forms do not
            bundle.mem_sign_ext = ~w_func3[2] & ~w_func3[1];
            bundle.immediate    = w_imm_i;
            bundle.rs1          = w_rs1;
            bundle.rd           = w_rd;
            uses_rs1            = 1'b1;
            if ((w_func3 == 3'b011) || (w_func3 == 3'b110) || (w_func3 == 3'b111))
               w_illegal = 1'b1;
         end
         c_OPC_STORE: begin
            bundle.alu_opcode = ALU_ADD;
            bundle.op1_sel    = 1'b1;
            bundle.op2_sel    = 1'b1;
            bundle.mem_wr_en  = 1'b1;
            bundle.mem_size   = w_func3[1:0];
            bundle.immediate  = w_imm_s;
            bundle.rs1        = w_rs1;
            bundle.rs2        = w_rs2;
            uses_rs1          = 1'b1;
            uses_rs2          = 1'b1;
            if (w_func3[2] || (w_func3[1:0] == 2'b11))
               w_illegal = 1'b1;
         end
         c_OPC_BRANCH: begin
            bundle.alu_opcode   = ALU_SUB;
            bundle.op1_sel      = 1'b1;
            bundle.op2_sel      = 1'b0;
            bundle.immediate    = w_imm_b;
            bundle.rs1          = w_rs1;
            bundle.rs2          = w_rs2;
            bundle.is_branch    = 1'b1;
            bundle.branch_func3 = w_func3;
            uses_rs1            = 1'b1;
            uses_rs2            = 1'b1;
            if (w_func3[2:1] == 2'b01)
               w_illegal = 1'b1;
         end
         c_OPC_JAL: begin
            bundle.alu_opcode = ALU_ADD;
            bundle.op1_sel    = 1'b0;
            bundle.op2_sel    = 1'b1;
            bundle.rf_wr_en   = 1'b1;
            bundle.rf_wb_sel  = c_WB_PC4;
            bundle.immediate  = w_imm_j;
            bundle.rd         = w_rd;
            bundle.is_jal     = 1'b1;
         end
         c_OPC_JALR: begin
            bundle.alu_opcode = ALU_ADD;
            bundle.op1_sel    = 1'b1;
            bundle.op2_sel    = 1'b1;
            bundle.rf_wr_en   = 1'b1;
            bundle.rf_wb_sel  = c_WB_PC4;
            bundle.immediate  = w_imm_i;
            bundle.rs1        = w_rs1;
            bundle.rd         = w_rd;
            bundle.is_jalr    = 1'b1;
            uses_rs1          = 1'b1;
            if (w_func3 != 3'b000)
               w_illegal = 1'b1;
         end
         c_OPC_LUI: begin
            bundle.alu_opcode = ALU_PASS_B;
            bundle.op1_sel    = 1'b0;
            bundle.op2_sel    = 1'b1;
            bundle.rf_wr_en   = 1'b1;
            bundle.rf_wb_sel  = c_WB_ALU;
            bundle.immediate  = w_imm_u;
            bundle.rd         = w_rd;
         end
         c_OPC_AUIPC: begin
            bundle.alu_opcode = ALU_ADD;
            bundle.op1_sel    = 1'b0;
            bundle.op2_sel    = 1'b1;
            bundle.rf_wr_en   = 1'b1;
            bundle.rf_wb_sel  = c_WB_ALU;
            bundle.immediate  = w_imm_u;
            bundle.rd         = w_rd;
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase

      // Illegal instructions still flow downstream but must have no side effects
      bundle.illegal = w_illegal;
      if (w_illegal) begin
         bundle.rf_wr_en  = 1'b0;
         bundle.mem_wr_en = 1'b0;
         bundle.mem_rd_en = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipelined_decode_control.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_decode_control
//  Description : Registered RV32I decode stage between fetch and execute.
//                Valid/ready handshake on both sides, load-use bubble
//                insertion, synchronous flush and a saturating bubble counter.
//  Ports       : clock, reset_n (async, active-low), flush
//                in_valid/in_ready/in_instruction/in_pc   fetch side
//                out_valid/out_ready/out_*                execute side
//                stall_count                              bubbles inserted
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_decode_control
   import decode_pkg::*;
#(
   parameter int XLEN          = 32,
   parameter int REG_ADDR_W    = 5,
   parameter bit ENABLE_HAZARD = 1'b1,
   parameter int STALL_CNT_W   = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_instruction,
   input  logic [XLEN-1:0]        in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_pc,
   output logic [3:0]             out_alu_opcode,
   output logic                   out_op1_sel,
   output logic                   out_op2_sel,
   output logic                   out_rf_wr_en,
   output logic [1:0]             out_rf_wb_sel,
   output logic                   out_mem_wr_en,
   output logic                   out_mem_rd_en,
   output logic [1:0]             out_mem_size,
   output logic                   out_mem_sign_ext,
   output logic [XLEN-1:0]        out_immediate,
   output logic [REG_ADDR_W-1:0]  out_rs1,
   output logic [REG_ADDR_W-1:0]  out_rs2,
   output logic [REG_ADDR_W-1:0]  out_rd,
   output logic                   out_is_branch,
   output logic                   out_is_jal,
   output logic                   out_is_jalr,
   output logic [2:0]             out_branch_func3,
   output logic                   out_illegal,
   output logic [STALL_CNT_W-1:0] stall_count
);

   decode_bundle_t         w_dec;
   logic                   w_uses_rs1;
   logic                   w_uses_rs2;
   logic                   w_adv;
   logic                   w_hz;

   decode_bundle_t         r_b;
   logic                   r_valid;
   logic [XLEN-1:0]        r_pc;
   logic [STALL_CNT_W-1:0] r_stall;

   decode_comb u_decode_comb (
      .instruction (in_instruction),
      .bundle      (w_dec),
      .uses_rs1    (w_uses_rs1),
      .uses_rs2    (w_uses_rs2)
   );

   assign w_adv = out_ready | ~r_valid;

   // A load sitting in the output register cannot forward its data to the
   // instruction behind it, so that instruction waits one cycle.
   generate
      if (ENABLE_HAZARD) begin : g_hazard
         assign w_hz = r_valid & r_b.mem_rd_en & (r_b.rd != '0) &
                       ((w_uses_rs1 & (w_dec.rs1 == r_b.rd)) |
                        (w_uses_rs2 & (w_dec.rs2 == r_b.rd)));
      end else begin : g_no_hazard
         assign w_hz = 1'b0;
      end
   endgenerate

   assign in_ready = w_adv & ~w_hz & ~flush;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_b     <= '0;
         r_stall <= '0;
      end else if (flush) begin
         r_valid       <= 1'b0;
         r_b.rf_wr_en  <= 1'b0;
         r_b.mem_wr_en <= 1'b0;
         r_b.mem_rd_en <= 1'b0;
      end else if (w_adv && w_hz) begin
         r_valid       <= 1'b0;
         r_b.rf_wr_en  <= 1'b0;
         r_b.mem_wr_en <= 1'b0;
         r_b.mem_rd_en <= 1'b0;
         if (r_stall != '1)
            r_stall <= r_stall + STALL_CNT_W'(1);
      end else if (w_adv && in_valid) begin
         r_valid <= 1'b1;
         r_pc    <= in_pc;
         r_b     <= w_dec;
      end else if (w_adv) begin
         r_valid       <= 1'b0;
         r_b.rf_wr_en  <= 1'b0;
         r_b.mem_wr_en <= 1'b0;
         r_b.mem_rd_en <= 1'b0;
      end
   end

   assign out_valid        = r_valid;
   assign out_pc           = r_pc;
   assign out_alu_opcode   = r_b.alu_opcode;
   assign out_op1_sel      = r_b.op1_sel;
   assign out_op2_sel      = r_b.op2_sel;
   assign out_rf_wr_en     = r_b.rf_wr_en;
   assign out_rf_wb_sel    = r_b.rf_wb_sel;
   assign out_mem_wr_en    = r_b.mem_wr_en;
   assign out_mem_rd_en    = r_b.mem_rd_en;
   assign out_mem_size     = r_b.mem_size;
   assign out_mem_sign_ext = r_b.mem_sign_ext;
   assign out_immediate    = r_b.immediate;
   assign out_rs1          = r_b.rs1;
   assign out_rs2          = r_b.rs2;
   assign out_rd           = r_b.rd;
   assign out_is_branch    = r_b.is_branch;
   assign out_is_jal       = r_b.is_jal;
   assign out_is_jalr      = r_b.is_jalr;
   assign out_branch_func3 = r_b.branch_func3;
   assign out_illegal      = r_b.illegal;
   assign stall_count      = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_decode_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_decode_control
//  Description : Directed bench for pipelined_decode_control. A decode vector
//                table plus hand-written handshake/hazard/flush/reset
//                sequences. A second instance with hazard detection disabled
//                shares the stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_decode_control;

   logic        clock;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instruction;
   logic [31:0] in_pc;

   // hazard-enabled instance
   logic        in_ready, out_valid, out_op1_sel, out_op2_sel, out_rf_wr_en;
   logic        out_mem_wr_en, out_mem_rd_en, out_mem_sign_ext, out_illegal;
   logic        out_is_branch, out_is_jal, out_is_jalr;
   logic [31:0] out_pc, out_immediate;
   logic [3:0]  out_alu_opcode;
   logic [1:0]  out_rf_wb_sel, out_mem_size;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [2:0]  out_branch_func3;
   logic [15:0] stall_count;

   // hazard-disabled instance
   logic        n_in_ready, n_out_valid, n_out_op1_sel, n_out_op2_sel, n_out_rf_wr_en;
   logic        n_out_mem_wr_en, n_out_mem_rd_en, n_out_mem_sign_ext, n_out_illegal;
   logic        n_out_is_branch, n_out_is_jal, n_out_is_jalr;
   logic [31:0] n_out_pc, n_out_immediate;
   logic [3:0]  n_out_alu_opcode;
   logic [1:0]  n_out_rf_wb_sel, n_out_mem_size;
   logic [4:0]  n_out_rs1, n_out_rs2, n_out_rd;
   logic [2:0]  n_out_branch_func3;
   logic [15:0] n_stall_count;

   pipelined_decode_control #(.ENABLE_HAZARD(1'b1)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instruction(in_instruction), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_alu_opcode(out_alu_opcode), .out_op1_sel(out_op1_sel),
      .out_op2_sel(out_op2_sel), .out_rf_wr_en(out_rf_wr_en),
      .out_rf_wb_sel(out_rf_wb_sel), .out_mem_wr_en(out_mem_wr_en),
      .out_mem_rd_en(out_mem_rd_en), .out_mem_size(out_mem_size),
      .out_mem_sign_ext(out_mem_sign_ext), .out_immediate(out_immediate),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_is_branch(out_is_branch), .out_is_jal(out_is_jal),
      .out_is_jalr(out_is_jalr), .out_branch_func3(out_branch_func3),
      .out_illegal(out_illegal), .stall_count(stall_count)
   );

   pipelined_decode_control #(.ENABLE_HAZARD(1'b0)) dut_nohz (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(n_in_ready),
      .in_instruction(in_instruction), .in_pc(in_pc),
      .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
      .out_alu_opcode(n_out_alu_opcode), .out_op1_sel(n_out_op1_sel),
      .out_op2_sel(n_out_op2_sel), .out_rf_wr_en(n_out_rf_wr_en),
      .out_rf_wb_sel(n_out_rf_wb_sel), .out_mem_wr_en(n_out_mem_wr_en),
      .out_mem_rd_en(n_out_mem_rd_en), .out_mem_size(n_out_mem_size),
      .out_mem_sign_ext(n_out_mem_sign_ext), .out_immediate(n_out_immediate),
      .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_rd(n_out_rd),
      .out_is_branch(n_out_is_branch), .out_is_jal(n_out_is_jal),
      .out_is_jalr(n_out_is_jalr), .out_branch_func3(n_out_branch_func3),
      .out_illegal(n_out_illegal), .stall_count(n_stall_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [31:0] alu, imm, rd, rs1, rs2, op1, op2, wr, wb;
      logic [31:0] mwr, mrd, size, sext, br, jal, jalr, f3, ill;
   } vec_t;

   function automatic vec_t mk(
      input logic [31:0] instr, alu, imm, rd, rs1, rs2, op1, op2, wr, wb,
      input logic [31:0] mwr, mrd, size, sext, br, jal, jalr, f3, ill);
      vec_t v;
      v.instr = instr; v.alu = alu; v.imm = imm; v.rd = rd; v.rs1 = rs1;
      v.rs2 = rs2; v.op1 = op1; v.op2 = op2; v.wr = wr; v.wb = wb;
      v.mwr = mwr; v.mrd = mrd; v.size = size; v.sext = sext; v.br = br;
      v.jal = jal; v.jalr = jalr; v.f3 = f3; v.ill = ill;
      return v;
   endfunction

   vec_t vecs[15];

   initial begin
      //              instr          alu imm          rd rs1 rs2 op1 op2 wr wb mwr mrd sz sx br jal jalr f3 ill
      vecs[0]  = mk(32'h00500093,  0, 32'h5,        1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // addi x1,x0,5
      vecs[1]  = mk(32'h123452B7, 10, 32'h12345000, 5, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // lui x5
      vecs[2]  = mk(32'hFFFFFFFF,  0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); // bad opcode
      vecs[3]  = mk(32'h402081B3,  1, 32'h0,        3, 1, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // sub x3,x1,x2
      vecs[4]  = mk(32'h0020A423,  0, 32'h8,        0, 1, 2, 1, 1, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0); // sw x2,8(x1)
      vecs[5]  = mk(32'hFFF08203,  0, 32'hFFFFFFFF, 4, 1, 0, 1, 1, 1, 2, 0, 1, 0, 1, 0, 0, 0, 0, 0); // lb x4,-1(x1)
      vecs[6]  = mk(32'h0020D203,  0, 32'h2,        4, 1, 0, 1, 1, 1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0); // lhu x4,2(x1)
      vecs[7]  = mk(32'hFE208EE3,  1, 32'hFFFFFFFC, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); // beq -4
      vecs[8]  = mk(32'h010000EF,  0, 32'h10,       1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); // jal x1,16
      vecs[9]  = mk(32'h00008067,  0, 32'h0,        0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); // jalr x0,0(x1)
      vecs[10] = mk(32'h00001397,  0, 32'h1000,     7, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // auipc x7,1
      vecs[11] = mk(32'h4030D313,  7, 32'h403,      6, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // srai x6,x1,3
      vecs[12] = mk(32'h022081B3,  0, 32'h0,        3, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1); // func7=1 illegal
      vecs[13] = mk(32'h0020F433,  9, 32'h0,        8, 1, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // and x8,x1,x2
      vecs[14] = mk(32'h00209463,  1, 32'h8,        0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0); // bne +8

      reset_n        = 1'b0;
      flush          = 1'b0;
      in_valid       = 1'b0;
      out_ready      = 1'b1;
      in_instruction = 32'h0;
      in_pc          = 32'h0;
      #12;
      chk("reset.out_valid", 32'(out_valid), 0);
      chk("reset.in_ready", 32'(in_ready), 1);
      chk("reset.illegal", 32'(out_illegal), 0);
      chk("reset.stall", 32'(stall_count), 0);
      reset_n = 1'b1;
      tick();

      // ---------------- decode table ----------------
      for (int i = 0; i < 15; i++) begin
         in_instruction = vecs[i].instr;
         in_pc          = 32'h100 + 32'(i * 4);
         in_valid       = 1'b1;
         tick();
         chk($sformatf("v%0d.valid", i), 32'(out_valid), 1);
         chk($sformatf("v%0d.pc", i), out_pc, 32'h100 + 32'(i * 4));
         chk($sformatf("v%0d.alu", i), 32'(out_alu_opcode), vecs[i].alu);
         chk($sformatf("v%0d.imm", i), out_immediate, vecs[i].imm);
         chk($sformatf("v%0d.rd", i), 32'(out_rd), vecs[i].rd);
         chk($sformatf("v%0d.rs1", i), 32'(out_rs1), vecs[i].rs1);
         chk($sformatf("v%0d.rs2", i), 32'(out_rs2), vecs[i].rs2);
         chk($sformatf("v%0d.op1", i), 32'(out_op1_sel), vecs[i].op1);
         chk($sformatf("v%0d.op2", i), 32'(out_op2_sel), vecs[i].op2);
         chk($sformatf("v%0d.wr", i), 32'(out_rf_wr_en), vecs[i].wr);
         chk($sformatf("v%0d.wb", i), 32'(out_rf_wb_sel), vecs[i].wb);
         chk($sformatf("v%0d.mwr", i), 32'(out_mem_wr_en), vecs[i].mwr);
         chk($sformatf("v%0d.mrd", i), 32'(out_mem_rd_en), vecs[i].mrd);
         chk($sformatf("v%0d.size", i), 32'(out_mem_size), vecs[i].size);
         chk($sformatf("v%0d.sext", i), 32'(out_mem_sign_ext), vecs[i].sext);
         chk($sformatf("v%0d.br", i), 32'(out_is_branch), vecs[i].br);
         chk($sformatf("v%0d.jal", i), 32'(out_is_jal), vecs[i].jal);
         chk($sformatf("v%0d.jalr", i), 32'(out_is_jalr), vecs[i].jalr);
         chk($sformatf("v%0d.f3", i), 32'(out_branch_func3), vecs[i].f3);
         chk($sformatf("v%0d.ill", i), 32'(out_illegal), vecs[i].ill);
         in_valid = 1'b0;
         tick();
         chk($sformatf("v%0d.idle", i), 32'(out_valid), 0);
      end
      chk("table.stall", 32'(stall_count), 0);

      // ---------------- load-use hazard: lw x2,0(x1) ; add x3,x2,x1 ----------------
      in_instruction = 32'h0000A103;
      in_pc          = 32'h200;
      in_valid       = 1'b1;
      tick();
      chk("hz.lw_valid", 32'(out_valid), 1);
      chk("hz.lw_mrd", 32'(out_mem_rd_en), 1);
      in_instruction = 32'h001101B3;
      in_pc          = 32'h204;
      #1;
      chk("hz.in_ready_blocked", 32'(in_ready), 0);
      chk("nohz.in_ready", 32'(n_in_ready), 1);
      tick();
      chk("hz.bubble_valid", 32'(out_valid), 0);
      chk("hz.bubble_mrd", 32'(out_mem_rd_en), 0);
      chk("hz.stall1", 32'(stall_count), 1);
      chk("hz.in_ready_after", 32'(in_ready), 1);
      chk("nohz.add_valid", 32'(n_out_valid), 1);
      chk("nohz.add_rd", 32'(n_out_rd), 3);
      chk("nohz.stall0", 32'(n_stall_count), 0);
      tick();
      chk("hz.add_valid", 32'(out_valid), 1);
      chk("hz.add_rd", 32'(out_rd), 3);
      chk("hz.add_rs1", 32'(out_rs1), 2);
      chk("hz.add_rs2", 32'(out_rs2), 1);
      chk("hz.add_pc", out_pc, 32'h204);
      chk("hz.stall_still1", 32'(stall_count), 1);
      in_valid = 1'b0;
      tick();
      chk("nohz.stall_end", 32'(n_stall_count), 0);

      // ---------------- backpressure ----------------
      in_instruction = 32'h00500093;   // addi x1,x0,5
      in_pc          = 32'h300;
      in_valid       = 1'b1;
      tick();
      out_ready      = 1'b0;
      in_instruction = 32'h00700113;   // addi x2,x0,7
      in_pc          = 32'h304;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp%0d.in_ready", c), 32'(in_ready), 0);
         chk($sformatf("bp%0d.valid", c), 32'(out_valid), 1);
         chk($sformatf("bp%0d.rd", c), 32'(out_rd), 1);
         chk($sformatf("bp%0d.imm", c), out_immediate, 32'h5);
         chk($sformatf("bp%0d.pc", c), out_pc, 32'h300);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp.in_ready_resume", 32'(in_ready), 1);
      tick();
      chk("bp.next_valid", 32'(out_valid), 1);
      chk("bp.next_rd", 32'(out_rd), 2);
      chk("bp.next_imm", out_immediate, 32'h7);
      chk("bp.next_pc", out_pc, 32'h304);
      in_valid = 1'b0;
      tick();
      chk("bp.drain", 32'(out_valid), 0);

      // ---------------- flush ----------------
      in_instruction = 32'h00500093;
      in_pc          = 32'h400;
      in_valid       = 1'b1;
      tick();
      chk("fl.pre_valid", 32'(out_valid), 1);
      flush    = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("fl.in_ready", 32'(in_ready), 0);
      tick();
      flush = 1'b0;
      chk("fl.valid", 32'(out_valid), 0);
      chk("fl.wr_en", 32'(out_rf_wr_en), 0);
      chk("fl.stall", 32'(stall_count), 1);

      // ---------------- asynchronous reset mid-stream ----------------
      in_instruction = 32'h123452B7;
      in_pc          = 32'h500;
      in_valid       = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("rst.pre_valid", 32'(out_valid), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst.valid", 32'(out_valid), 0);
      chk("rst.rd", 32'(out_rd), 0);
      chk("rst.imm", out_immediate, 0);
      chk("rst.alu", 32'(out_alu_opcode), 0);
      chk("rst.wr", 32'(out_rf_wr_en), 0);
      chk("rst.pc", out_pc, 0);
      chk("rst.stall", 32'(stall_count), 0);
      chk("rst.in_ready", 32'(in_ready), 1);
      #1 reset_n = 1'b1;
      tick();
      chk("rst.post_valid", 32'(out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
